// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and defaults for the UART program loader
package prog_loader_pkg;
  localparam int PROG_DEPTH = 16;
  localparam int CLKS_PER_BIT_DEF = 234;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  typedef enum logic [1:0] {RUN, LOAD, CHECK, ERR} ld_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: serial line, CPU fetch port and loader status
interface prog_loader_if;
  logic       uart_rx;
  logic [3:0] pc;
  logic [7:0] dout;
  logic       cpu_reset_n;
  logic       loading;
  logic       load_done;
  logic       chk_err;
  modport master (input uart_rx, pc, output dout, cpu_reset_n, loading, load_done, chk_err);
  modport slave (output uart_rx, pc, input dout, cpu_reset_n, loading, load_done, chk_err);
endinterface

// File: rtl/prog_loader_uart_rx.sv
// uart_rx: 8N1 receiver with start-bit glitch rejection and framing check
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  rx_state_e   state_q, state_d;
  logic [2:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        valid_q, valid_d, ferr_q, ferr_d;
  logic        s, fall, hit;
  // sync_q[1:0] is the two-flop synchronizer; sync_q[2] only serves edge detection
  assign s    = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign hit  = cnt_q == (state_q == RX_START ? HALF : FULL);
  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      sync_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[1:0], rx};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end
  // next state: a start bit that is high again at half-bit is a glitch
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      RX_START: if (hit) state_d = s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (hit && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (hit) state_d = RX_IDLE;
    endcase
  end
  // bit timing, LSB-first shift and one-cycle result strobes
  always_comb begin
    cnt_d   = (state_q == RX_IDLE || hit) ? '0 : cnt_q + 16'd1;
    bit_d   = (state_q == RX_DATA) ? bit_q + 3'(hit) : '0;
    shift_d = (state_q == RX_DATA && hit) ? {s, shift_q[7:1]} : shift_q;
    valid_d = state_q == RX_STOP && hit && s;
    ferr_d  = state_q == RX_STOP && hit && !s;
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a 16-byte program over UART while holding the CPU in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input logic           clk,
  input logic           reset,
  prog_loader_if.master bus
);
  ld_state_e  state_q, state_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] sum_q, sum_d;
  logic       chk_err_q, chk_err_d, crn_q, done_q, done_d;
  logic [7:0] mem_q [PROG_DEPTH];
  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr, start, we;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (bus.uart_rx),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );
  assign bus.dout        = mem_q[bus.pc];
  assign bus.cpu_reset_n = crn_q;
  assign bus.load_done   = done_q;
  assign bus.chk_err     = chk_err_q;
  // state register; cpu_reset_n and load_done register off state_d so they rise together
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      addr_q    <= '0;
      sum_q     <= '0;
      chk_err_q <= 1'b0;
      crn_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
      crn_q     <= state_d == RUN;
      done_q    <= done_d;
    end
  end
  // next state: sync restarts only from RUN/ERR; framing errors abort a load
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN, ERR: if (rx_valid && rx_byte == SYNC_BYTE) state_d = LOAD;
      LOAD:     if (rx_ferr) state_d = ERR;
                else if (rx_valid && addr_q == 4'hF) state_d = CHECK;
      CHECK:    if (rx_ferr) state_d = ERR;
                else if (rx_valid) state_d = (rx_byte == sum_q) ? RUN : ERR;
    endcase
  end
  // outputs and datapath next values
  always_comb begin
    start       = (state_q == RUN || state_q == ERR) && rx_valid && rx_byte == SYNC_BYTE;
    we          = state_q == LOAD && rx_valid;
    done_d      = state_q == CHECK && rx_valid && rx_byte == sum_q;
    addr_d      = start ? '0 : we ? addr_q + 4'd1 : addr_q;
    sum_d       = start ? '0 : we ? sum_q + rx_byte : sum_q;
    chk_err_d   = start ? 1'b0 : (state_d == ERR && state_q != ERR) ? 1'b1 : chk_err_q;
    bus.loading = state_q == LOAD || state_q == CHECK;
  end
  // program memory, cleared to no-ops on reset
  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: 8'h00};
    else if (we) mem_q[addr_q] <= rx_byte;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, meaning clk cycles per UART bit (27 MHz / 115200).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the load-start marker.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 pc  input  4  CPU program counter, the read address.
REQ-007 dout  output  8  instruction byte at mem[pc].
REQ-008 cpu_reset_n  output  1  registered active-low hold for the CPU; 0 holds the CPU.
REQ-009 loading  output  1  high in LOAD or CHECK state.
REQ-010 load_done  output  1  one-cycle pulse on successful load.
REQ-011 chk_err  output  1  sticky; set on checksum mismatch or framing error during a load.

Function
REQ-012 SHALL store a 16 x 8 program memory; dout = mem[pc] combinationally, with no cycle of latency.
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer before any use.
REQ-014 Receiver SHALL detect the start bit on a synchronized falling edge and re-check it low at CLKS_PER_BIT/2.
  - If the line is high at that check, it SHALL return to idle (glitch rejection).
REQ-015 Receiver SHALL sample data bits at mid-bit, one every CLKS_PER_BIT cycles, then sample the stop bit.
REQ-016 Receiver SHALL emit rx_valid for exactly one cycle with rx_byte, one bit-time after the last data bit sample.
  - A stop bit of 1 gives a valid byte.
  - A stop bit of 0 raises rx_ferr for one cycle instead, and the byte is discarded.
REQ-017 Loader FSM SHALL have the states RUN, LOAD, CHECK and ERR.
REQ-018 RUN:
  - cpu_reset_n = 1.
  - rx byte == SYNC_BYTE -> LOAD, with addr = 0, sum = 0, chk_err cleared.
  - Any other byte is ignored.
  - rx_ferr is ignored.
REQ-019 LOAD:
  - cpu_reset_n = 0.
  - Each valid byte writes mem[addr], addr += 1, sum = (sum + byte) mod 256.
  - The write with addr == 15 -> CHECK.
REQ-020 CHECK: next valid byte == sum -> RUN, with load_done pulsed in the same cycle that cpu_reset_n rises. Otherwise -> ERR with chk_err = 1.
REQ-021 rx_ferr in LOAD or CHECK -> ERR with chk_err = 1; memory written so far is retained.
REQ-022 ERR:
  - cpu_reset_n = 0.
  - SYNC_BYTE -> LOAD, with chk_err cleared and addr and sum zeroed.
  - Other bytes are ignored.
REQ-023 A SYNC_BYTE value received in LOAD or CHECK SHALL be treated as data, not as a restart.
REQ-024 addr SHALL be 4 bits and sum 8 bits, both wrapping modulo 2^width; no other overflow handling.
REQ-025 Memory writes SHALL occur only in LOAD, on the rx_valid cycle; the write is visible on dout from the next cycle.

Reset
REQ-026 While reset is high, the state SHALL go to RUN and the receiver to idle, with addr = 0, sum = 0, chk_err = 0, load_done = 0.
REQ-027 Reset SHALL drive cpu_reset_n = 0; it SHALL read 1 from the first cycle after reset deasserts.
REQ-028 Reset SHALL clear all 16 memory words to 8'h00, which the CPU executes as a no-op move.
REQ-029 Reset asserted mid-byte or mid-load SHALL abandon the partial byte and load without further writes.

Structure
REQ-030 Package prog_loader_pkg SHALL hold:
  - the loader state enum;
  - PROG_DEPTH = 16;
  - SYNC_BYTE default;
  - CLKS_PER_BIT default.
REQ-031 The serial receiver SHALL be a separate sub-module uart_rx.
  - Ports: clk, reset, rx, rx_byte, rx_valid, rx_ferr.
  - It is instantiated once.
  - The loader FSM and memory stay in prog_loader.

Verification (CLKS_PER_BIT = 4)
REQ-032 Reset, then pc = 0..15 -> dout = 8'h00 for all; cpu_reset_n = 1 from the cycle after reset falls.
REQ-033 Send A5, bytes 01..10 hex, checksum 88 hex. Required response:
  - loading high from the A5 byte to the checksum byte;
  - mem[n] = n+1;
  - one load_done pulse;
  - cpu_reset_n returns to 1;
  - chk_err = 0.
REQ-034 Same as REQ-033 but with checksum 87 hex -> ERR, chk_err = 1, cpu_reset_n stays 0. Then repeat the valid load -> chk_err = 0, RUN.
REQ-035 In RUN, send 3C then 5A -> no state change and memory unchanged. In LOAD, send A5 as data -> it is stored at the current addr.
REQ-036 During LOAD byte 5, drive the stop bit low -> chk_err = 1, ERR, mem[0..4] retained. A one-cycle low glitch on rx in RUN -> no byte is received.
REQ-037 Assert reset after byte 8 of a load -> RUN, memory all 8'h00, cpu_reset_n = 1 after release, no load_done.
